// File: rtl/jk_reg_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_reg_writer_pkg
// Purpose  : Shared definitions for the JK register writer: operation codes,
//            FSM state encoding and the default register width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package jk_reg_writer_pkg;

  // Operation codes as seen on the op input.
  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_SET    = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_TOGGLE = 2'd3
  } op_e;

  // Writer FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int C_DEFAULT_WIDTH = 8;

endpackage
`default_nettype wire

// File: rtl/jk_excite.sv
`default_nettype none
// ============================================================================
// Module   : jk_excite
// Purpose  : Combinational J/K excitation generator for an array of JK cells.
//            Produces all-zero excitations unless enabled.
// Ports    : op   - latched operation code
//            data - latched operand (load value or bit mask)
//            q    - current cell outputs
//            en   - apply enable; when low every cell holds
//            j, k - per-bit excitation vectors
// Revision : 1.0 - initial release
// ============================================================================
module jk_excite
  import jk_reg_writer_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_WIDTH
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] q,
  input  logic             en,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  always_comb begin
    j = '0;
    k = '0;
    if (en) begin
      case (op)
        // LOAD only excites bits that differ from the target, so loading
        // the current value produces no excitation at all.
        OP_LOAD: begin
          j = data & ~q;
          k = ~data & q;
        end
        OP_SET:   j = data;
        OP_CLEAR: k = data;
        OP_TOGGLE: begin
          j = data;
          k = data;
        end
        default: begin
          j = '0;
          k = '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/jk_reg_writer.sv
`default_nettype none
// ============================================================================
// Module   : jk_reg_writer
// Purpose  : Writes an array of JK storage cells through a fixed-latency
//            IDLE -> APPLY -> CHECK -> DONE sequence, then verifies the
//            result against a value predicted at request time.
// Ports    : clk    - system clock, rising edge
//            _reset - asynchronous active-low reset
//            req    - write request, sampled in IDLE only
//            op     - LOAD / SET / CLEAR / TOGGLE
//            data   - load value or bit mask
//            busy   - high whenever not IDLE
//            ack    - one-cycle completion pulse (DONE state)
//            err    - verify mismatch of the last completed operation
//            q, _q  - true / complement cell outputs
// Revision : 1.0 - initial release
// ============================================================================
module jk_reg_writer
  import jk_reg_writer_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             _reset,
  input  logic             req,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             ack,
  output logic             err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] _q
);

  state_e           r_state;
  state_e           w_state_nxt;
  op_e              r_op;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_exp;
  logic [WIDTH-1:0] r_q;
  logic             r_err;
  logic             w_apply;
  logic             w_accept;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_q_nxt;

  // Value the cells should hold once the operation has been applied.
  function automatic logic [WIDTH-1:0] f_expected(
    input op_e              f_op,
    input logic [WIDTH-1:0] f_data,
    input logic [WIDTH-1:0] f_q
  );
    case (f_op)
      OP_LOAD:   f_expected = f_data;
      OP_SET:    f_expected = f_q | f_data;
      OP_CLEAR:  f_expected = f_q & ~f_data;
      default:   f_expected = f_q ^ f_data;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    ack         = 1'b0;
    w_apply     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (req) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_APPLY;
        end
      end
      ST_APPLY: begin
        w_apply     = 1'b1;
        w_state_nxt = ST_CHECK;
      end
      ST_CHECK: w_state_nxt = ST_DONE;
      ST_DONE: begin
        ack         = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch; expected value is predicted from q at the accept edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      r_op   <= OP_LOAD;
      r_data <= '0;
      r_exp  <= '0;
    end else if (w_accept) begin
      r_op   <= op_e'(op);
      r_data <= data;
      r_exp  <= f_expected(op_e'(op), data, r_q);
    end
  end

  // --------------------------------------------------------------------------
  // JK cell array. Excitations are zero outside APPLY, so the cells only
  // change on the APPLY -> CHECK edge.
  // --------------------------------------------------------------------------
  jk_excite #(
    .WIDTH (WIDTH)
  ) u_excite (
    .op   (r_op),
    .data (r_data),
    .q    (r_q),
    .en   (w_apply),
    .j    (w_j),
    .k    (w_k)
  );

  // JK characteristic: Q+ = J&~Q | ~K&Q (J&K toggles, J sets, K clears).
  assign w_q_nxt = (w_j & ~r_q) | (~w_k & r_q);

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Verify flag: loaded in CHECK, held until the next CHECK.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      r_err <= 1'b0;
    end else if (r_state == ST_CHECK) begin
      r_err <= (r_q != r_exp);
    end
  end

  assign err = r_err;
  assign q   = r_q;
  assign _q  = ~r_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_reg_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_reg_writer
// Purpose  : Self-checking bench for jk_reg_writer with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_reg_writer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic [1:0]   op;
  logic [W-1:0] data;
  logic         busy;
  logic         ack;
  logic         err;
  logic [W-1:0] q;
  logic [W-1:0] nq;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] m_q;   // model of the register contents

  // per-cycle capture of one operation (index = edges after the request edge)
  logic [3:0]        c_busy, c_ack, c_err;
  logic [3:0][W-1:0] c_q, c_nq;
  logic [W-1:0]      c_jk;

  always #5 clk = ~clk;

  jk_reg_writer #(.WIDTH(W)) dut (
    .clk    (clk),
    ._reset (rst_n),
    .req    (req),
    .op     (op),
    .data   (data),
    .busy   (busy),
    .ack    (ack),
    .err    (err),
    .q      (q),
    ._q     (nq)
  );

  function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] d,
                                              input logic [W-1:0] cur);
    case (o)
      2'd0:    return d;
      2'd1:    return cur | d;
      2'd2:    return cur & ~d;
      default: return cur ^ d;
    endcase
  endfunction

  // Issue one request and record outputs at the falling edge after each of
  // the next four rising edges. Inputs are scrambled while busy.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] d);
    @(negedge clk);
    req = 1'b1; op = o; data = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      c_busy[i] = busy; c_ack[i] = ack; c_err[i] = err; c_q[i] = q; c_nq[i] = nq;
      if (i == 0) begin
        c_jk = dut.w_j | dut.w_k;
        req  = 1'($urandom); op = 2'($urandom); data = W'($urandom);
      end
      if (i == 2) req = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = 1'b0; op = '0; data = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (q !== 8'h00)  begin n_bad++; $display("FAIL reset_q got %h want 00", q); end
    n_cmp++; if (nq !== 8'hFF) begin n_bad++; $display("FAIL reset_nq got %h want ff", nq); end
    n_cmp++; if ({busy, ack, err} !== 3'b000)
      begin n_bad++; $display("FAIL reset_flags busy/ack/err got %b want 000", {busy, ack, err}); end
    rst_n = 1'b1;
    m_q   = '0;
  endtask

  task automatic test_directed;
    logic [1:0]   t_op [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [W-1:0] t_d  [4] = '{8'hA5, 8'h0F, 8'hA0, 8'hFF};
    logic [W-1:0] t_q  [4] = '{8'hA5, 8'hAF, 8'h0F, 8'hF0};
    for (int n = 0; n < 4; n++) begin
      logic [W-1:0] old_q;
      old_q = m_q;
      run_op(t_op[n], t_d[n]);
      m_q = t_q[n];
      for (int c = 0; c < 4; c++) begin
        logic [W-1:0] eq;
        eq = (c == 0) ? old_q : m_q;
        n_cmp++; if (c_busy[c] !== (c < 3))
          begin n_bad++; $display("FAIL dir%0d busy@%0d got %b want %b", n, c, c_busy[c], c < 3); end
        n_cmp++; if (c_ack[c] !== (c == 2))
          begin n_bad++; $display("FAIL dir%0d ack@%0d got %b want %b", n, c, c_ack[c], c == 2); end
        n_cmp++; if (c_q[c] !== eq)
          begin n_bad++; $display("FAIL dir%0d q@%0d got %h want %h", n, c, c_q[c], eq); end
        n_cmp++; if (c_nq[c] !== ~eq)
          begin n_bad++; $display("FAIL dir%0d nq@%0d got %h want %h", n, c, c_nq[c], ~eq); end
      end
      n_cmp++; if (c_err[2] !== 1'b0)
        begin n_bad++; $display("FAIL dir%0d err got %b want 0", n, c_err[2]); end
    end
  endtask

  task automatic test_load_same;
    run_op(2'd0, 8'h3C);
    m_q = 8'h3C;
    run_op(2'd0, 8'h3C);
    n_cmp++; if (c_jk !== 8'h00) begin n_bad++; $display("FAIL load_same_jk got %h want 00", c_jk); end
    n_cmp++; if (c_q[3] !== 8'h3C) begin n_bad++; $display("FAIL load_same_q got %h want 3c", c_q[3]); end
    n_cmp++; if (c_ack[2] !== 1'b1 || c_err[2] !== 1'b0)
      begin n_bad++; $display("FAIL load_same_ack_err got %b%b want 10", c_ack[2], c_err[2]); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      logic [1:0]   o;
      logic [W-1:0] d, old_q;
      o     = 2'($urandom);
      d     = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      old_q = m_q;
      run_op(o, d);
      m_q = ref_result(o, d, old_q);
      n_cmp++; if (c_q[0] !== old_q || c_q[1] !== m_q || c_q[3] !== m_q)
        begin n_bad++; $display("FAIL rnd%0d op%0d d=%h q got %h/%h/%h want %h/%h/%h", n, o, d,
                                c_q[0], c_q[1], c_q[3], old_q, m_q, m_q); end
      n_cmp++; if (c_nq[1] !== ~m_q)
        begin n_bad++; $display("FAIL rnd%0d nq got %h want %h", n, c_nq[1], ~m_q); end
      n_cmp++; if (c_ack !== 4'b0100 || c_busy !== 4'b0111)
        begin n_bad++; $display("FAIL rnd%0d ack/busy got %b/%b want 0100/0111", n, c_ack, c_busy); end
      n_cmp++; if (c_err[2] !== 1'b0)
        begin n_bad++; $display("FAIL rnd%0d err got %b want 0", n, c_err[2]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0]   s_op;
    logic [W-1:0] s_d, pend;
    pend = m_q;
    @(negedge clk);
    for (int t = 0; t < 24; t++) begin
      req = 1'b1; op = 2'($urandom); data = W'($urandom);
      s_op = op; s_d = data;
      @(posedge clk);
      if (t % 4 == 0) pend = ref_result(s_op, s_d, m_q);
      if (t % 4 == 1) m_q = pend;
      @(negedge clk);
      n_cmp++; if (busy !== (t % 4 != 3) || ack !== (t % 4 == 2))
        begin n_bad++; $display("FAIL b2b t%0d busy/ack got %b%b want %b%b", t, busy, ack,
                                t % 4 != 3, t % 4 == 2); end
      n_cmp++; if (q !== m_q) begin n_bad++; $display("FAIL b2b t%0d q got %h want %h", t, q, m_q); end
    end
    req = 1'b0;
  endtask

  task automatic test_stuck;
    run_op(2'd0, 8'h00);
    m_q = 8'h00;
    force dut.r_q = 8'h00;
    run_op(2'd0, 8'h01);
    release dut.r_q;
    n_cmp++; if (c_ack[2] !== 1'b1 || c_err[2] !== 1'b1)
      begin n_bad++; $display("FAIL stuck_ack_err got %b%b want 11", c_ack[2], c_err[2]); end
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL stuck_hold err got %b want 1", err); end
    end
    run_op(2'd0, 8'h5A);
    m_q = 8'h5A;
    n_cmp++; if (c_err[1:0] !== 2'b11 || c_err[2] !== 1'b0)
      begin n_bad++; $display("FAIL stuck_clear err got %b want 011 (c2..c0)", c_err[2:0]); end
    n_cmp++; if (c_q[1] !== 8'h5A) begin n_bad++; $display("FAIL stuck_reload q got %h want 5a", c_q[1]); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req = 1'b1; op = 2'd0; data = 8'hFF;
    @(negedge clk);             // APPLY
    req = 1'b0;
    @(negedge clk);             // CHECK
    n_cmp++; if (q !== 8'hFF) begin n_bad++; $display("FAIL rmid_pre q got %h want ff", q); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (q !== 8'h00 || nq !== 8'hFF)
      begin n_bad++; $display("FAIL rmid_q got %h/%h want 00/ff", q, nq); end
    n_cmp++; if ({busy, ack, err} !== 3'b000)
      begin n_bad++; $display("FAIL rmid_flags got %b want 000", {busy, ack, err}); end
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (ack !== 1'b0 || q !== 8'h00)
        begin n_bad++; $display("FAIL rmid_hold ack/q got %b/%h want 0/00", ack, q); end
    end
    // release reset with a request already waiting
    rst_n = 1'b1; req = 1'b1; op = 2'd1; data = 8'h81;
    @(negedge clk);
    req = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL first_req busy got %b want 1", busy); end
    @(negedge clk);
    n_cmp++; if (q !== 8'h81) begin n_bad++; $display("FAIL first_req q got %h want 81", q); end
    @(negedge clk);
    n_cmp++; if (ack !== 1'b1 || err !== 1'b0)
      begin n_bad++; $display("FAIL first_req ack/err got %b%b want 10", ack, err); end
    @(negedge clk);
    m_q = 8'h81;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached, simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_load_same();
    test_random();
    test_back_to_back();
    test_stuck();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
